fetch_sequencer: RTL

//  Program sequencer for the 9-bit instruction ROM. It owns the program counter that drives the
//  ROM address input and consumes the ROM's combinational instruction output. It runs the

---
 rtl/fetch_sequencer_if.sv | 40 ++++
 rtl/fetch_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// ----------------------------------------------------------------------------
// fetch_sequencer_if
//   Bundles the program-control, branch and instruction-ROM signals of the
//   fetch sequencer. Clock and reset are kept out of the bundle.
//
//   master modport : the sequencer itself
//     in  Start, Stall, BranchEn, BranchAbs, BranchTarget[D], InstIn[9]
//     out PrgCtr[D], InstValid, Running, Ack, InstCount[CW]
//   slave modport  : the surrounding top level / ROM / decoder
//     mirror image of master
// ----------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int D  = 12,
    parameter int CW = 16
);
    // Control / decoder side
    logic          Start;
    logic          Stall;
    logic          BranchEn;
    logic          BranchAbs;
    logic [D-1:0]  BranchTarget;
    // ROM side
    logic [8:0]    InstIn;
    logic [D-1:0]  PrgCtr;
    // Status
    logic          InstValid;
    logic          Running;
    logic          Ack;
    logic [CW-1:0] InstCount;

    modport master (
        input  Start, Stall, BranchEn, BranchAbs, BranchTarget, InstIn,
        output PrgCtr, InstValid, Running, Ack, InstCount
    );

    modport slave (
        output Start, Stall, BranchEn, BranchAbs, BranchTarget, InstIn,
        input  PrgCtr, InstValid, Running, Ack, InstCount
    );
endinterface

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
//   Program sequencer for the 9-bit instruction ROM. Owns the program counter
//   (ROM address), runs the Start/Ack program handshake, applies decoder
//   branches (absolute or signed PC-relative), stops on the halt opcode and
//   counts retired instructions with a saturating counter.
//
//   Ports
//     Clk    in  clock, all state updates on the rising edge
//     Reset  in  synchronous active-high reset (highest priority)
//     bus    fetch_sequencer_if.master
//              Start        level, launches the program from IDLE or DONE
//              Stall        freezes PC/count and masks branch/halt
//              BranchEn     branch request for the current instruction
//              BranchAbs    1 = absolute target, 0 = signed PC offset
//              BranchTarget target address or two's-complement offset
//              InstIn       ROM data for the current PrgCtr (combinational)
//              PrgCtr       registered ROM address
//              InstValid    current instruction is live and not a halt
//              Running      sequencer is in RUN
//              Ack          program finished (DONE)
//              InstCount    retired instructions since the last start
// ----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int           D          = 12,
    parameter logic [D-1:0] START_ADDR = '0,
    parameter logic [8:0]   HALT_CODE  = 9'b111111111,
    parameter int           CW         = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    fetch_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_e        state_q, state_d;
    logic [D-1:0]  pc_q,    pc_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic          is_halt;
    logic          inst_valid;

    assign is_halt    = (bus.InstIn == HALT_CODE);
    // Live instruction this cycle: retires and may redirect the PC.
    assign inst_valid = (state_q == RUN) && !bus.Stall && !is_halt;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a hold value first, so no
        // path through the case/if tree can leave it unassigned (no latch).
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.Start) begin
                    state_d = RUN;
                    pc_d    = START_ADDR;
                    cnt_d   = '0;
                end
            end

            RUN: begin
                if (bus.Stall) begin
                    // Frozen: branch and halt of this cycle are ignored.
                end else if (is_halt) begin
                    // Halt wins over a simultaneous branch; PC stays on it.
                    state_d = DONE;
                end else begin
                    if (bus.BranchEn) begin
                        if (bus.BranchAbs) begin
                            pc_d = bus.BranchTarget;
                        end else begin
                            // Offset has the PC's width, so a plain D-bit
                            // add equals PC + sign-extended offset mod 2**D.
                            pc_d = pc_q + bus.BranchTarget;
                        end
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end

                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: everything but InstValid comes straight from flops.
    // ------------------------------------------------------------------
    assign bus.PrgCtr    = pc_q;
    assign bus.Running   = (state_q == RUN);
    assign bus.Ack       = (state_q == DONE);
    assign bus.InstCount = cnt_q;
    assign bus.InstValid = inst_valid;

endmodule
